// File: rtl/ex_mult_unit.sv
// Multi-cycle integer multiply unit: accepts one MUL-class op from the issue queue,
// waits LATENCY cycles, then holds the result on the CDB until the arbiter grants it.
module ex_mult_unit #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [XLEN-1:0] issue_op1,
    input  logic [XLEN-1:0] issue_op2,
    input  logic [1:0]      issue_funct,
    input  logic [5:0]      issue_rd_tag,
    output logic            ex_done,
    output logic            cdb_req,
    input  logic            cdb_grant,
    output logic [5:0]      cdb_tag,
    output logic [XLEN-1:0] cdb_data,
    output logic            cdb_data_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    localparam logic [1:0] FUNCT_MUL    = 2'b00;
    localparam logic [1:0] FUNCT_MULH   = 2'b01;
    localparam logic [1:0] FUNCT_MULHU  = 2'b11;

    localparam logic [3:0] CNT_INIT     = 4'(LATENCY - 1);
    localparam logic [1:0] ACCEPT_STATE = (LATENCY == 1) ? S_PUBLISH : S_BUSY;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5:0]      tag_q, tag_d;
    logic [XLEN-1:0] result_q, result_d;

    // One extra bit per operand lets a single signed multiplier cover all four
    // signedness combinations; zero-extension makes an operand read as unsigned.
    logic                     op1_signed, op2_signed;
    logic signed [XLEN:0]     op1_ext, op2_ext;
    logic signed [2*XLEN+1:0] product;
    logic [XLEN-1:0]          product_sel;
    logic                     product_unused;

    assign op1_signed     = (issue_funct != FUNCT_MULHU);
    assign op2_signed     = (issue_funct == FUNCT_MUL) || (issue_funct == FUNCT_MULH);
    assign op1_ext        = {op1_signed & issue_op1[XLEN-1], issue_op1};
    assign op2_ext        = {op2_signed & issue_op2[XLEN-1], issue_op2};
    assign product        = op1_ext * op2_ext;
    assign product_sel    = (issue_funct == FUNCT_MUL) ? product[XLEN-1:0]
                                                       : product[2*XLEN-1:XLEN];
    assign product_unused = ^product[2*XLEN+1:2*XLEN];

    // NOTE: every next-state signal takes its held value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    tag_d    = issue_rd_tag;
                    result_d = product_sel;
                    cnt_d    = CNT_INIT;
                    state_d  = ACCEPT_STATE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                if (cdb_grant) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    // ex_done is a pure state decode so it never loops back through the queue's issue mux.
    assign ex_done        = (state_q == S_IDLE);
    assign cdb_req        = (state_q == S_PUBLISH);
    assign cdb_data_valid = cdb_req && cdb_grant;
    assign cdb_tag        = tag_q;
    assign cdb_data       = result_q;

endmodule

// File: tb/tb_ex_mult_unit.sv
// Self-checking bench for ex_mult_unit: directed corner cases plus randomized ops
// compared against a plain 64-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_mult_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // Main instance, LATENCY=4
    logic        issue_valid = 1'b0;
    logic [31:0] issue_op1 = '0, issue_op2 = '0;
    logic [1:0]  issue_funct = '0;
    logic [5:0]  issue_rd_tag = '0;
    logic        cdb_grant = 1'b0;
    logic        ex_done, cdb_req, cdb_data_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    // Second instance, LATENCY=1
    logic        l1_valid = 1'b0;
    logic [31:0] l1_op1 = '0, l1_op2 = '0;
    logic [1:0]  l1_funct = '0;
    logic [5:0]  l1_rd_tag = '0;
    logic        l1_grant = 1'b0;
    logic        l1_ex_done, l1_req, l1_data_valid;
    logic [5:0]  l1_tag;
    logic [31:0] l1_data;

    ex_mult_unit #(.LATENCY(LAT), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_funct(issue_funct), .issue_rd_tag(issue_rd_tag),
        .ex_done(ex_done), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_data_valid(cdb_data_valid)
    );

    ex_mult_unit #(.LATENCY(1), .XLEN(32)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(l1_valid), .issue_op1(l1_op1), .issue_op2(l1_op2),
        .issue_funct(l1_funct), .issue_rd_tag(l1_rd_tag),
        .ex_done(l1_ex_done), .cdb_req(l1_req), .cdb_grant(l1_grant),
        .cdb_tag(l1_tag), .cdb_data(l1_data), .cdb_data_valid(l1_data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V M-extension semantics using 64-bit host arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (f)
            2'b00:   begin p = 64'(sa * sb); return p[31:0];  end
            2'b01:   begin p = 64'(sa * sb); return p[63:32]; end
            2'b10:   begin p = 64'(sa * ub); return p[63:32]; end
            default: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
        endcase
    endfunction

    // Issues one op on the LATENCY=4 unit from a negedge with the unit idle; grant is
    // tied high when hold==0, otherwise withheld for hold cycles of cdb_req.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] t, input logic [31:0] exp, input int hold,
                          input string name);
        cdb_grant    = (hold == 0);
        issue_valid  = 1'b1;
        issue_funct  = f;
        issue_op1    = a;
        issue_op2    = b;
        issue_rd_tag = t;
        checks++;
        if (ex_done !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: ex_done=%b expected 1", name, ex_done);
        end
        @(negedge clk);
        issue_valid  = 1'b0;
        issue_op1    = $urandom;
        issue_op2    = $urandom;
        issue_funct  = 2'($urandom);
        issue_rd_tag = 6'($urandom);
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if ({cdb_req, cdb_data_valid, ex_done} !== 3'b000) begin
                failures++;
                $display("FAIL %s busy%0d: req/valid/ex_done=%b%b%b expected 000",
                         name, k, cdb_req, cdb_data_valid, ex_done);
            end
            @(negedge clk);
        end
        checks++;
        if (cdb_req !== 1'b1 || cdb_tag !== t || cdb_data !== exp) begin
            failures++;
            $display("FAIL %s publish: req=%b tag=%h data=%h expected req=1 tag=%h data=%h",
                     name, cdb_req, cdb_tag, cdb_data, t, exp);
        end
        for (int k = 0; k < hold; k++) begin
            checks++;
            if ({cdb_req, cdb_data_valid, ex_done} !== 3'b100 || cdb_tag !== t || cdb_data !== exp) begin
                failures++;
                $display("FAIL %s hold%0d: req/valid/ex_done=%b%b%b tag=%h data=%h expected 100 tag=%h data=%h",
                         name, k, cdb_req, cdb_data_valid, ex_done, cdb_tag, cdb_data, t, exp);
            end
            @(negedge clk);
        end
        cdb_grant = 1'b1;
        #1;
        checks++;
        if ({cdb_req, cdb_data_valid, ex_done} !== 3'b110 || cdb_tag !== t || cdb_data !== exp) begin
            failures++;
            $display("FAIL %s grant: req/valid/ex_done=%b%b%b tag=%h data=%h expected 110 tag=%h data=%h",
                     name, cdb_req, cdb_data_valid, ex_done, cdb_tag, cdb_data, t, exp);
        end
        @(negedge clk);
        cdb_grant = 1'b0;
        checks++;
        if ({cdb_req, ex_done} !== 2'b01) begin
            failures++;
            $display("FAIL %s after: req/ex_done=%b%b expected 01", name, cdb_req, ex_done);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({ex_done, cdb_req, cdb_data_valid} !== 3'b100 || cdb_tag !== 6'h0 || cdb_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ex_done/req/valid=%b%b%b tag=%h data=%h expected 100 0 0",
                     ex_done, cdb_req, cdb_data_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 6'h12, 32'hFFFF_FFEB, 0, "mul_7x-3");
    endtask

    task automatic test_high_funcs;
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 6'h01, 32'h4000_0000, 0, "mulh_min");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h02, 32'hFFFF_FFFE, 0, "mulhu_max");
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h03, 32'hFFFF_FFFF, 0, "mulhsu_neg");
    endtask

    task automatic test_backpressure;
        run_op(2'b00, 32'd1000, 32'd3000, 6'h2C, 32'd3000000, 5, "backpressure");
    endtask

    task automatic test_back_to_back;
        logic [31:0] a[3], b[3];
        logic [5:0]  t[3];
        logic [1:0]  f[3];
        int          acc[3];
        int          idx = 0;
        int          budget = 0;
        logic [5:0]  pub_tag[$];
        logic [31:0] pub_data[$];
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
            f[i] = 2'($urandom);
            t[i] = 6'(8 + i);
        end
        cdb_grant = 1'b1;
        while (budget < 60 && !(idx == 3 && pub_tag.size() == 3 && ex_done)) begin
            if (cdb_data_valid) begin
                pub_tag.push_back(cdb_tag);
                pub_data.push_back(cdb_data);
            end
            if (ex_done && idx < 3) begin
                issue_valid  = 1'b1;
                issue_op1    = a[idx];
                issue_op2    = b[idx];
                issue_funct  = f[idx];
                issue_rd_tag = t[idx];
                acc[idx]     = cyc;
                idx++;
            end else if (ex_done) begin
                issue_valid = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        issue_valid = 1'b0;
        cdb_grant   = 1'b0;
        checks++;
        if (pub_tag.size() != 3 || idx != 3) begin
            failures++;
            $display("FAIL b2b_count: accepted=%0d published=%0d expected 3 and 3", idx, pub_tag.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != LAT + 1) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: gap=%0d expected %0d", i, acc[i] - acc[i-1], LAT + 1);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pub_tag[i] !== t[i] || pub_data[i] !== ref_mul(f[i], a[i], b[i])) begin
                    failures++;
                    $display("FAIL b2b_order%0d: tag=%h data=%h expected tag=%h data=%h",
                             i, pub_tag[i], pub_data[i], t[i], ref_mul(f[i], a[i], b[i]));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_latency_one;
        l1_valid  = 1'b1;
        l1_funct  = 2'b00;
        l1_op1    = 32'd6;
        l1_op2    = 32'd7;
        l1_rd_tag = 6'h2A;
        l1_grant  = 1'b0;
        @(negedge clk);
        l1_valid = 1'b0;
        checks++;
        if ({l1_req, l1_ex_done} !== 2'b10 || l1_tag !== 6'h2A || l1_data !== 32'd42) begin
            failures++;
            $display("FAIL lat1_req: req/ex_done=%b%b tag=%h data=%h expected 10 tag=2a data=0000002a",
                     l1_req, l1_ex_done, l1_tag, l1_data);
        end
        l1_grant = 1'b1;
        #1;
        checks++;
        if (l1_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL lat1_valid: cdb_data_valid=%b expected 1", l1_data_valid);
        end
        @(negedge clk);
        l1_grant = 1'b0;
        checks++;
        if ({l1_req, l1_ex_done} !== 2'b01) begin
            failures++;
            $display("FAIL lat1_done: req/ex_done=%b%b expected 01", l1_req, l1_ex_done);
        end
    endtask

    task automatic test_random;
        logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a, b;
        logic [1:0]  f;
        logic [5:0]  t;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            f = 2'($urandom);
            t = 6'($urandom);
            run_op(f, a, b, t, ref_mul(f, a, b), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_op;
        issue_valid  = 1'b1;
        issue_funct  = 2'b00;
        issue_op1    = 32'd5;
        issue_op2    = 32'd9;
        issue_rd_tag = 6'h3F;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_done, cdb_req} !== 2'b10 || cdb_tag !== 6'h0 || cdb_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: ex_done/req=%b%b tag=%h data=%h expected 10 0 0",
                     ex_done, cdb_req, cdb_tag, cdb_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        cdb_grant = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({cdb_data_valid, cdb_req, ex_done} !== 3'b001) begin
                failures++;
                $display("FAIL reset_release%0d: valid/req/ex_done=%b%b%b expected 001",
                         k, cdb_data_valid, cdb_req, ex_done);
            end
        end
        cdb_grant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_high_funcs();
        test_backpressure();
        test_back_to_back();
        test_latency_one();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
